// File: rtl/hilo_pkg.sv
// Shared types and widths for the HI/LO multiply controller.
package hilo_pkg;

    localparam int CNT_W  = 4;
    localparam int HILO_W = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } hilo_state_t;

endpackage

// File: rtl/mul32.sv
// Combinational signed 32x32 -> 64 multiplier; treated as a multicycle path.
module mul32
    import hilo_pkg::*;
(
    input  logic signed [HILO_W-1:0]   i_a,
    input  logic signed [HILO_W-1:0]   i_b,
    output logic signed [2*HILO_W-1:0] o_p
);

    // Full-width signed product
    always_comb begin
        o_p = 64'(i_a) * 64'(i_b);
    end

endmodule

// File: rtl/hilo_mul_ctrl.sv
// Multicycle multiply controller with HI/LO register pair and MTHI/MTLO writes.
// Operands are held in r_a/r_b for SETTLE_CYCLES before the product is captured.
module hilo_mul_ctrl
    import hilo_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [HILO_W-1:0] op_a,
    input  logic [HILO_W-1:0] op_b,
    input  logic              hi_wr,
    input  logic              lo_wr,
    input  logic [HILO_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              wr_err,
    output logic [HILO_W-1:0] hi_out,
    output logic [HILO_W-1:0] lo_out
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    hilo_state_t        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [HILO_W-1:0]  r_a;
    logic [HILO_W-1:0]  r_b;
    logic [HILO_W-1:0]  r_hi;
    logic [HILO_W-1:0]  r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_wr_err;

    hilo_state_t        w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [HILO_W-1:0]  w_a_nxt;
    logic [HILO_W-1:0]  w_b_nxt;
    logic [HILO_W-1:0]  w_hi_nxt;
    logic [HILO_W-1:0]  w_lo_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_wr_err_nxt;
    logic [2*HILO_W-1:0] w_prod;

    mul32 u_mul (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    // Next-state, counter, operand and HI/LO update logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_wr_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (hi_wr) begin
                    w_hi_nxt = wr_data;
                end else begin
                    w_hi_nxt = r_hi;
                end
                if (lo_wr) begin
                    w_lo_nxt = wr_data;
                end else begin
                    w_lo_nxt = r_lo;
                end
                if (start) begin
                    w_a_nxt     = op_a;
                    w_b_nxt     = op_b;
                    w_cnt_nxt   = CNT_LOAD;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SETTLE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SETTLE: begin
                // Writes while the product is settling are dropped and flagged
                w_wr_err_nxt = hi_wr | lo_wr;
                if (r_cnt != {CNT_W{1'b0}}) begin
                    w_cnt_nxt   = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SETTLE;
                end else begin
                    w_hi_nxt    = w_prod[2*HILO_W-1:HILO_W];
                    w_lo_nxt    = w_prod[HILO_W-1:0];
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_a      <= {HILO_W{1'b0}};
            r_b      <= {HILO_W{1'b0}};
            r_hi     <= {HILO_W{1'b0}};
            r_lo     <= {HILO_W{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_wr_err <= w_wr_err_nxt;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign wr_err = r_wr_err;
    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Self-checking bench for hilo_mul_ctrl: timeline model checked every cycle plus literal pins.
module tb_hilo_mul_ctrl;

    localparam int S = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        wr_err;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_cmp  = 0;
    int n_fail = 0;

    hilo_mul_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .hi_wr   (hi_wr),
        .lo_wr   (lo_wr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .wr_err  (wr_err),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a multiply accepted at edge e lands at edge e+S; writes only count while none is in flight.
    int          edge_n = 0;
    int          m_cap  = 0;
    bit          m_fly  = 1'b0;
    bit          m_valid = 1'b0;
    logic [63:0] m_prod;
    logic [31:0] m_hi, m_lo;
    logic        m_done, m_err;

    always @(posedge clock) begin
        if (reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_err = 1'b0;
            m_fly = 1'b0; m_valid = 1'b1;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_fly) begin
                m_err = hi_wr | lo_wr;
                if (edge_n == m_cap) begin
                    m_hi   = m_prod[63:32];
                    m_lo   = m_prod[31:0];
                    m_done = 1'b1;
                    m_fly  = 1'b0;
                end
            end else begin
                if (hi_wr) m_hi = wr_data;
                if (lo_wr) m_lo = wr_data;
                if (start) begin
                    m_prod = 64'(longint'($signed(op_a)) * longint'($signed(op_b)));
                    m_cap  = edge_n + S;
                    m_fly  = 1'b1;
                end
            end
        end
        edge_n++;
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (m_valid) begin
            chk("m_busy",   {31'd0, busy},   {31'd0, m_fly});
            chk("m_done",   {31'd0, done},   {31'd0, m_done});
            chk("m_wr_err", {31'd0, wr_err}, {31'd0, m_err});
            chk("m_hi",     hi_out, m_hi);
            chk("m_lo",     lo_out, m_lo);
        end
    end

    // Start one multiply and pin busy/done timing and the captured result
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(negedge clock);
        start = 1'b1; op_a = a; op_b = b;
        @(negedge clock);
        start = 1'b0; op_a = 32'hA5A5_A5A5; op_b = 32'h5A5A_5A5A;
        for (int k = 1; k <= S + 1; k++) begin
            chk("lit_busy", {31'd0, busy}, {31'd0, (k <= S)});
            chk("lit_done", {31'd0, done}, {31'd0, (k == S + 1)});
            if (k <= S) @(negedge clock);
        end
        chk("lit_hi", hi_out, exp_hi);
        chk("lit_lo", lo_out, exp_lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op_a = 32'd0; op_b = 32'd0;
        hi_wr = 1'b0; lo_wr = 1'b0; wr_data = 32'd0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_done",   {31'd0, done},   32'd0);
        chk("rst_wr_err", {31'd0, wr_err}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        reset = 1'b0;

        run_mul(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_mul(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_mul(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001);

        // MTHI in IDLE
        @(negedge clock);
        hi_wr = 1'b1; wr_data = 32'h1234_5678;
        @(negedge clock);
        hi_wr = 1'b0;
        chk("mthi_hi", hi_out, 32'h1234_5678);
        chk("mthi_err", {31'd0, wr_err}, 32'd0);

        // MTLO during SETTLE is dropped and flagged
        @(negedge clock);
        start = 1'b1; op_a = 32'd6; op_b = 32'd7;
        @(negedge clock);
        start = 1'b0; lo_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(negedge clock);
        lo_wr = 1'b0;
        chk("settle_lo_kept", lo_out, 32'h8000_0001);
        chk("settle_err", {31'd0, wr_err}, 32'd1);
        @(negedge clock);
        chk("settle_err_clr", {31'd0, wr_err}, 32'd0);
        chk("settle_done", {31'd0, done}, 32'd1);
        chk("settle_hi", hi_out, 32'd0);
        chk("settle_lo", lo_out, 32'd42);

        // Both writes together, then start with a write in the same cycle
        @(negedge clock);
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hCAFE_F00D;
        @(negedge clock);
        hi_wr = 1'b0; lo_wr = 1'b0;
        chk("both_hi", hi_out, 32'hCAFE_F00D);
        chk("both_lo", lo_out, 32'hCAFE_F00D);
        start = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; hi_wr = 1'b1; wr_data = 32'h0BAD_0BAD;
        @(negedge clock);
        start = 1'b0; hi_wr = 1'b0;
        chk("start_wr_hi", hi_out, 32'h0BAD_0BAD);
        repeat (S) @(negedge clock);
        chk("start_wr_prod_hi", hi_out, 32'd0);
        chk("start_wr_prod_lo", lo_out, 32'd1);

        // start held high for 10 cycles with changing operands
        @(negedge clock);
        start = 1'b1; op_a = 32'd1; op_b = 32'd2;
        for (int i = 1; i < 10; i++) begin
            @(negedge clock);
            op_a = 32'(i + 1); op_b = 32'(i + 2);
        end
        @(negedge clock);
        start = 1'b0;
        repeat (S) @(negedge clock);
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_lo", lo_out, 32'd110);

        // Reset mid-multiply discards the product
        @(negedge clock);
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(negedge clock);
        start = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_hi", hi_out, 32'd0);
        chk("mid_lo", lo_out, 32'd0);
        chk("mid_busy_clr", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("mid_no_done", {31'd0, done}, 32'd0);
        end
        run_mul(32'd2, 32'd3, 32'd0, 32'd6);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
